// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers
module uart_tx_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 4096,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       cfg_wr,
    input  logic [1:0]                 cfg_parity_type,
    input  logic [1:0]                 cfg_baud_rate,
    output logic                       tx_send,
    output logic [7:0]                 tx_data,
    output logic [1:0]                 tx_parity_type,
    output logic [1:0]                 tx_baud_rate,
    input  logic                       tx_active,
    input  logic                       tx_done,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);
    localparam int IW   = $clog2(NUM_REQ);
    localparam int CMAX = ACK_TIMEOUT > GAP_CYCLES ? ACK_TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [IW-1:0] rr, win;
    logic          any, accept, ack_expired, gap_last, pend;
    logic [1:0]    pend_par, pend_baud;
    logic [7:0]    bytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
        assign bytes[g] = req_data[8*g +: 8];
    end

    // first valid requester at or after the round-robin pointer; the descending scan leaves the nearest one
    always_comb begin
        win = rr;
        any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[IW'((int'(rr) + k) % NUM_REQ)]) begin
                win = IW'((int'(rr) + k) % NUM_REQ);
                any = 1'b1;
            end
        end
    end

    // a config update in IDLE takes the cycle, so a grant waits one cycle behind it
    assign accept      = state == IDLE && !(cfg_wr || pend) && any;
    assign req_ready   = (accept && reset_n) ? NUM_REQ'(1) << win : '0;
    assign tx_send     = state == START;
    assign busy        = state != IDLE;
    assign ack_expired = cnt == CW'(ACK_TIMEOUT - 1);
    assign gap_last    = GAP_CYCLES <= 1 || cnt == CW'(GAP_CYCLES - 1);

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // next-state: grant, wait for acknowledge, wait for frame end, then the idle gap
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = accept ? START : IDLE;
            START:     state_n = tx_active ? WAIT_DONE : ack_expired ? GAP : START;
            WAIT_DONE: state_n = (!tx_active && tx_done) ? GAP : WAIT_DONE;
            GAP:       state_n = gap_last ? IDLE : GAP;
            default:   state_n = IDLE;
        endcase
    end

    // phase counter, captured byte, pointer and config; config reaches the transmitter only in IDLE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            timeout_err    <= 1'b0;
            tx_data        <= '0;
            grant_id       <= '0;
            rr             <= '0;
            tx_parity_type <= '0;
            tx_baud_rate   <= '0;
            pend           <= 1'b0;
            pend_par       <= '0;
            pend_baud      <= '0;
        end else begin
            cnt         <= state_n != state ? '0 : cnt + 1'b1;
            timeout_err <= state == START && !tx_active && ack_expired;
            if (accept) begin
                tx_data  <= bytes[win];
                grant_id <= win;
                rr       <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
            end
            if (state == IDLE && cfg_wr) begin
                tx_parity_type <= cfg_parity_type;
                tx_baud_rate   <= cfg_baud_rate;
                pend           <= 1'b0;
            end else if (state == IDLE && pend) begin
                tx_parity_type <= pend_par;
                tx_baud_rate   <= pend_baud;
                pend           <= 1'b0;
            end else if (cfg_wr) begin
                pend      <= 1'b1;
                pend_par  <= cfg_parity_type;
                pend_baud <= cfg_baud_rate;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed bench with a frame-level reference model checked every cycle
module tb_uart_tx_scheduler;
    localparam int N   = 4;
    localparam int ACK = 8;
    localparam int GAP = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        cfg_wr;
    logic [1:0]  cfg_parity_type, cfg_baud_rate;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic [1:0]  tx_parity_type, tx_baud_rate;
    logic        tx_active, tx_done;
    logic [1:0]  grant_id;
    logic        busy, timeout_err;
    bit          tx_alive;

    uart_tx_scheduler #(.NUM_REQ(N), .ACK_TIMEOUT(ACK), .GAP_CYCLES(GAP)) dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_wr(cfg_wr), .cfg_parity_type(cfg_parity_type),
        .cfg_baud_rate(cfg_baud_rate), .tx_send(tx_send), .tx_data(tx_data),
        .tx_parity_type(tx_parity_type), .tx_baud_rate(tx_baud_rate), .tx_active(tx_active),
        .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    initial forever #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int r);
        for (int k = 0; k < N; k++)
            if (v[2'((r + k) % N)]) return (r + k) % N;
        return -1;
    endfunction

    // reference model: send age, frame-on-wire flag and remaining gap replace any state machine
    int         m_send_age = -1, m_gap_left = 0, m_gid = 0, m_rr = 0, m_win;
    bit         m_on_wire = 0, m_pend = 0, m_terr = 0, m_idle;
    logic [1:0] m_pp = 0, m_pb = 0, m_par = 0, m_baud = 0;
    logic [7:0] m_data = 0, m_wdata;
    logic [3:0] m_exp_ready;

    always_comb begin
        m_idle      = !(m_send_age >= 0 || m_on_wire || m_gap_left > 0);
        m_win       = pick(req_valid, m_rr);
        m_wdata     = m_win >= 0 ? 8'(req_data >> (8 * m_win)) : 8'h00;
        m_exp_ready = (reset_n && m_idle && !cfg_wr && !m_pend && m_win >= 0) ? 4'(1 << m_win) : 4'b0000;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_send_age <= -1; m_gap_left <= 0; m_on_wire <= 0; m_pend <= 0; m_terr <= 0;
            m_gid <= 0; m_rr <= 0; m_data <= 0; m_par <= 0; m_baud <= 0; m_pp <= 0; m_pb <= 0;
        end else begin
            m_terr <= 0;
            if (m_idle) begin
                if (cfg_wr) begin
                    m_par <= cfg_parity_type; m_baud <= cfg_baud_rate; m_pend <= 0;
                end else if (m_pend) begin
                    m_par <= m_pp; m_baud <= m_pb; m_pend <= 0;
                end else if (m_win >= 0) begin
                    m_data <= m_wdata; m_gid <= m_win; m_rr <= (m_win + 1) % N; m_send_age <= 0;
                end
            end else begin
                if (cfg_wr) begin
                    m_pend <= 1; m_pp <= cfg_parity_type; m_pb <= cfg_baud_rate;
                end
                if (m_send_age >= 0) begin
                    if (tx_active) begin
                        m_send_age <= -1; m_on_wire <= 1;
                    end else if (m_send_age == ACK - 1) begin
                        m_send_age <= -1; m_terr <= 1; m_gap_left <= GAP > 0 ? GAP : 1;
                    end else m_send_age <= m_send_age + 1;
                end else if (m_on_wire) begin
                    if (!tx_active && tx_done) begin
                        m_on_wire <= 0; m_gap_left <= GAP > 0 ? GAP : 1;
                    end
                end else m_gap_left <= m_gap_left - 1;
            end
        end
    end

    // every-cycle comparison of all outputs against the model
    always @(negedge clock) begin
        chk("req_ready", 32'(req_ready), 32'(m_exp_ready));
        chk("tx_send", 32'(tx_send), 32'(m_send_age >= 0));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("tx_parity_type", 32'(tx_parity_type), 32'(m_par));
        chk("tx_baud_rate", 32'(tx_baud_rate), 32'(m_baud));
        chk("busy", 32'(busy), 32'(!m_idle));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    end

    // transmitter stand-in: acknowledges two cycles after send, frame of five cycles, then done pulse
    initial begin
        int lat, len;
        tx_active = 0; tx_done = 0; lat = 0; len = 0;
        forever begin
            @(posedge clock);
            #1;
            tx_done = 0;
            if (!reset_n) begin
                tx_active = 0; lat = 0; len = 0;
            end else if (tx_active) begin
                len++;
                if (len == 5) begin tx_active = 0; tx_done = 1; end
            end else if (tx_send && tx_alive) begin
                lat++;
                if (lat == 2) begin tx_active = 1; lat = 0; len = 0; end
            end else lat = 0;
        end
    end

    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int w, sends, gaps, terrs;
        int order [8];
        int share [4];
        bit seen;
        logic [3:0] rdy;
        req_valid = 0; req_data = 0; cfg_wr = 0; cfg_parity_type = 0; cfg_baud_rate = 0; tx_alive = 1;
        tick(2);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_send", 32'(tx_send), 0);
        chk("rst_baud", 32'(tx_baud_rate), 0);
        reset_n = 1;
        cfg_wr = 1; cfg_parity_type = 2'b01; cfg_baud_rate = 2'b10;
        tick(1);
        cfg_wr = 0;
        chk("cfg_parity", 32'(tx_parity_type), 32'h1);
        chk("cfg_baud", 32'(tx_baud_rate), 32'h2);
        chk("cfg_busy", 32'(busy), 0);
        req_data = 32'h00A5_0000; req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        tick(1);
        req_valid = 0;
        chk("single_data", 32'(tx_data), 32'hA5);
        chk("single_gid", 32'(grant_id), 2);
        chk("single_send", 32'(tx_send), 1);
        chk("single_ready_pulse", 32'(req_ready), 0);
        sends = 0; gaps = 0; seen = 0;
        for (w = 0; w < 200; w++) begin
            @(negedge clock);
            if (!busy) break;
            sends += int'(tx_send);
            if (seen) gaps++;
            if (tx_done) seen = 1;
        end
        chk("single_idle_wait", 32'(w < 200), 1);
        chk("single_send_cycles", 32'(sends), 2);
        chk("single_gap_cycles", 32'(gaps), 16);

        reset_n = 0;
        tick(1);
        reset_n = 1;
        req_data = 32'h4433_2211; req_valid = 4'hF;
        share = '{0, 0, 0, 0};
        for (int f = 0; f < 8; f++) begin
            for (w = 0; w < 100; w++) begin
                @(negedge clock);
                if (req_ready != 0) break;
            end
            chk("rr_grant_wait", 32'(w < 100), 1);
            order[f] = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) order[f] = i;
            if (order[f] >= 0) share[order[f]]++;
            @(posedge clock);
            #1;
        end
        req_valid = 0;
        for (int f = 0; f < 8; f++) chk("rr_order", 32'(order[f]), 32'(exp_order[f]));
        for (int i = 0; i < N; i++) chk("rr_share", 32'(share[i]), 2);
        for (w = 0; w < 200; w++) begin @(negedge clock); if (!busy) break; end
        chk("rr_idle_wait", 32'(w < 200), 1);

        tick(1);
        tx_alive = 0; req_valid = 4'b0110;
        #1;
        chk("to_first_ready", 32'(req_ready), 32'h2);
        tick(1);
        req_valid = 4'b0100;
        sends = 0; terrs = 0; rdy = 0;
        for (w = 0; w < 100; w++) begin
            @(negedge clock);
            sends += int'(tx_send);
            terrs += int'(timeout_err);
            if (timeout_err) tx_alive = 1;
            if (req_ready != 0) begin rdy = req_ready; break; end
        end
        chk("to_wait", 32'(w < 100), 1);
        chk("to_send_cycles", 32'(sends), 8);
        chk("to_err_pulses", 32'(terrs), 1);
        chk("to_next_grant", 32'(rdy), 32'h4);
        @(posedge clock);
        #1;
        req_valid = 0;
        for (w = 0; w < 200; w++) begin @(negedge clock); if (!busy) break; end
        chk("to_idle_wait", 32'(w < 200), 1);

        tick(1);
        req_valid = 4'b1000;
        tick(1);
        req_valid = 0;
        for (w = 0; w < 50; w++) begin @(negedge clock); if (tx_active) break; end
        chk("cfgw_active_wait", 32'(w < 50), 1);
        tick(1);
        cfg_wr = 1; cfg_parity_type = 2'b00; cfg_baud_rate = 2'b11;
        tick(1);
        cfg_wr = 0;
        chk("cfgw_baud_held", 32'(tx_baud_rate), 0);
        chk("cfgw_busy", 32'(busy), 1);
        req_valid = 4'b0001;
        for (w = 0; w < 100; w++) begin @(negedge clock); if (!busy) break; end
        chk("cfgw_idle_wait", 32'(w < 100), 1);
        chk("cfgw_first_idle_ready", 32'(req_ready), 0);
        chk("cfgw_first_idle_baud", 32'(tx_baud_rate), 0);
        @(negedge clock);
        chk("cfgw_applied_baud", 32'(tx_baud_rate), 32'h3);
        chk("cfgw_grant_after", 32'(req_ready), 32'h1);
        @(posedge clock);
        #1;
        req_valid = 0;
        for (w = 0; w < 200; w++) begin @(negedge clock); if (!busy) break; end
        chk("cfgw_end_wait", 32'(w < 200), 1);

        tick(1);
        req_valid = 4'b0100;
        for (w = 0; w < 20; w++) begin @(negedge clock); if (tx_send) break; end
        chk("arst_send_wait", 32'(w < 20), 1);
        req_valid = 4'hF;
        #2;
        reset_n = 0;
        #1;
        chk("arst_send", 32'(tx_send), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(req_ready), 0);
        tick(2);
        reset_n = 1;
        #1;
        chk("arst_first_grant", 32'(req_ready), 32'h1);
        tick(1);
        req_valid = 0;
        for (w = 0; w < 200; w++) begin @(negedge clock); if (!busy) break; end
        chk("arst_end_wait", 32'(w < 200), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
